alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 41 ++++
 rtl/rr_arbiter2.sv | 48 ++++
 rtl/alu_arbiter.sv | 154 +++++++++++++++
 tb/tb_alu_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: fixed widths,
// opcode encodings, flag bit positions and the controller state encoding.
package alu_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 8;
  localparam int FLAG_W = 6;
  localparam int NREQ   = 2;

  // Opcode encodings understood by the downstream ALU
  localparam logic [OP_W-1:0] OP_NOP = 8'h00;
  localparam logic [OP_W-1:0] OP_LD  = 8'h01;
  localparam logic [OP_W-1:0] OP_ADD = 8'h03;
  localparam logic [OP_W-1:0] OP_SUB = 8'h04;
  localparam logic [OP_W-1:0] OP_AND = 8'h05;
  localparam logic [OP_W-1:0] OP_OR  = 8'h06;
  localparam logic [OP_W-1:0] OP_XOR = 8'h07;
  localparam logic [OP_W-1:0] OP_NOT = 8'h08;
  localparam logic [OP_W-1:0] OP_SL  = 8'h09;
  localparam logic [OP_W-1:0] OP_SR  = 8'h0A;

  // Bit positions inside the {z,n,c,v,s,h} flag vector
  localparam int FLAG_Z = 5;
  localparam int FLAG_N = 4;
  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_H = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  // True for every opcode the ALU can execute (LD and ADD..SR; 02 is a hole)
  function automatic logic op_supported(input logic [OP_W-1:0] op);
    return (op == OP_LD) || ((op >= OP_ADD) && (op <= OP_SR));
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The pointer names the requester that wins a
// tie; it moves to the other requester only when a grant is actually taken.
module rr_arbiter2
  import alu_arbiter_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            accept,
  output logic [NREQ-1:0] grant,
  output logic            grant_id
);

  logic prio_q;
  logic prio_d;

  // Pick the winner: a lone requester wins outright, a tie goes to the pointer
  always_comb begin
    grant_id = 1'b0;
    grant    = 2'b00;
    if (req == 2'b11) begin
      grant_id = prio_q;
    end else if (req[1]) begin
      grant_id = 1'b1;
    end
    if (req != 2'b00) begin
      grant = grant_id ? 2'b10 : 2'b01;
    end
  end

  // After a taken grant, favour the requester that was just passed over
  always_comb begin
    prio_d = prio_q;
    if (accept) begin
      prio_d = ~grant_id;
    end
  end

  // Pointer register; reset favours requester 0
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters. One transaction is in
// flight at a time: IDLE grants and latches a request, ISSUE drives the ALU
// for exactly one cycle, RESP holds the captured result until the owner
// takes it. Unsupported opcodes skip the ALU and answer with an error.
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  input  logic [NREQ*OP_W-1:0]   req_op,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]      rsp_data,
  output logic [FLAG_W-1:0]      rsp_flags,
  output logic                   rsp_err,
  output logic [DATA_W-1:0]      alu_a,
  output logic [DATA_W-1:0]      alu_b,
  output logic [OP_W-1:0]        alu_op,
  input  logic [DATA_W-1:0]      alu_out,
  input  logic [FLAG_W-1:0]      alu_flags,
  output logic                   busy
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic                id_q, id_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [FLAG_W-1:0]   rsp_flags_q, rsp_flags_d;
  logic                rsp_err_q, rsp_err_d;

  logic [NREQ-1:0]     arb_grant;
  logic                arb_id;
  logic                accept;
  logic [DATA_W-1:0]   sel_a;
  logic [DATA_W-1:0]   sel_b;
  logic [OP_W-1:0]     sel_op;

  rr_arbiter2 u_rr (
    .clk      (clk),
    .rst      (rst),
    .req      (req_valid),
    .accept   (accept),
    .grant    (arb_grant),
    .grant_id (arb_id)
  );

  // Only an idle, out-of-reset controller offers a grant
  always_comb begin
    req_ready = 2'b00;
    if ((state_q == ST_IDLE) && !rst) begin
      req_ready = arb_grant;
    end
  end

  assign accept = |(req_valid & req_ready);

  // Operand mux for the granted requester
  always_comb begin
    sel_a  = arb_id ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
    sel_b  = arb_id ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
    sel_op = arb_id ? req_op[2*OP_W-1:OP_W]    : req_op[OP_W-1:0];
  end

  // Controller next state and datapath register updates
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    id_d        = id_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d  = sel_a;
          b_d  = sel_b;
          op_d = sel_op;
          id_d = arb_id;
          if (op_supported(sel_op)) begin
            state_d = ST_ISSUE;
          end else begin
            // No ALU issue: answer immediately with a zeroed error response
            state_d     = ST_RESP;
            rsp_data_d  = '0;
            rsp_flags_d = '0;
            rsp_err_d   = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        // The ALU settled on the negedge inside this cycle
        rsp_data_d  = alu_out;
        rsp_flags_d = alu_flags;
        rsp_err_d   = 1'b0;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready[id_q]) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything visible
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_NOP;
      id_q        <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      id_q        <= id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Output decode: ALU opcode only during ISSUE, response bit only for the owner
  always_comb begin
    alu_a     = a_q;
    alu_b     = b_q;
    alu_op    = (state_q == ST_ISSUE) ? op_q : OP_NOP;
    rsp_valid = 2'b00;
    if (state_q == ST_RESP) begin
      rsp_valid = id_q ? 2'b10 : 2'b01;
    end
    rsp_data  = rsp_data_q;
    rsp_flags = rsp_flags_q;
    rsp_err   = rsp_err_q;
    busy      = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter. A small ALU stand-in answers on negedge;
// every expected value below is a hand-computed constant.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic [15:0] req_op = '0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = 2'b00;
  logic [31:0] rsp_data;
  logic [5:0]  rsp_flags;
  logic        rsp_err;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [7:0]  alu_op;
  logic [31:0] alu_out = '0;
  logic [5:0]  alu_flags = '0;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // ALU stand-in. Flag convention: z=zero, n=bit31, c=carry (ADD) or
  // a<b borrow (SUB), v=carry/borrow into bit 31, s=n^v, h=nibble carry/borrow.
  function automatic logic [37:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [7:0] op);
    logic [32:0] w;
    logic [31:0] r;
    logic [31:0] lo;
    logic c, v, h;
    c = 1'b0; v = 1'b0; h = 1'b0; r = '0; w = '0; lo = '0;
    case (op)
      OP_LD:  r = a;
      OP_ADD: begin
        w  = {1'b0, a} + {1'b0, b};
        r  = w[31:0];
        c  = w[32];
        lo = {1'b0, a[30:0]} + {1'b0, b[30:0]};
        v  = lo[31];
        h  = ({1'b0, a[3:0]} + {1'b0, b[3:0]}) > 5'd15;
      end
      OP_SUB: begin
        r = a - b;
        c = a < b;
        v = a[30:0] < b[30:0];
        h = a[3:0] < b[3:0];
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOT: r = ~a;
      OP_SL:  r = a << b[4:0];
      OP_SR:  r = a >> b[4:0];
      default: r = '0;
    endcase
    return {r, (r == 32'd0), r[31], c, v, r[31] ^ v, h};
  endfunction

  always @(negedge clk) begin
    if (alu_op != OP_NOP) begin
      {alu_out, alu_flags} <= alu_model(alu_a, alu_b, alu_op);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b11;
    req_op = {OP_ADD, OP_ADD};
    req_a = {32'd4, 32'd3};
    cyc(); cyc(); #1;
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
    n_checks++; if (alu_op !== 8'h00) begin n_fail++; $display("FAIL reset_alu_op: got %h expected 00", alu_op); end
    n_checks++; if (alu_a !== 32'd0 || alu_b !== 32'd0) begin n_fail++; $display("FAIL reset_alu_ab: got %h/%h expected 0/0", alu_a, alu_b); end
    n_checks++; if (rsp_data !== 32'd0 || rsp_flags !== 6'd0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp: got %h/%b/%b expected 0/0/0", rsp_data, rsp_flags, rsp_err); end
    req_valid = 2'b00;
    rst = 1'b0;
    cyc();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_no_accept: busy got %b expected 0", busy); end
  endtask

  task automatic test_add_req0();
    req_a = {32'd0, 32'd5};
    req_b = {32'd0, 32'd7};
    req_op = {OP_NOP, OP_ADD};
    rsp_ready = 2'b01;
    req_valid = 2'b01;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL add_req_ready: got %b expected 01", req_ready); end
    cyc();
    req_valid = 2'b00;
    n_checks++; if (alu_op !== 8'h03 || alu_a !== 32'd5 || alu_b !== 32'd7) begin n_fail++; $display("FAIL add_issue: got op %h a %h b %h expected 03/5/7", alu_op, alu_a, alu_b); end
    n_checks++; if (rsp_valid !== 2'b00 || busy !== 1'b1) begin n_fail++; $display("FAIL add_t1: got rsp_valid %b busy %b expected 00/1", rsp_valid, busy); end
    cyc();
    n_checks++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL add_rsp_valid: got %b expected 01", rsp_valid); end
    n_checks++; if (rsp_data !== 32'd12 || rsp_flags !== 6'b000000 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL add_rsp: got %h/%b/%b expected 0000000c/000000/0", rsp_data, rsp_flags, rsp_err); end
    n_checks++; if (alu_op !== 8'h00) begin n_fail++; $display("FAIL add_alu_op_resp: got %h expected 00", alu_op); end
    cyc();
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 2'b00) begin n_fail++; $display("FAIL add_done: got busy %b rsp_valid %b expected 0/00", busy, rsp_valid); end
  endtask

  task automatic test_sub_req1();
    req_a = {32'd3, 32'd0};
    req_b = {32'd5, 32'd0};
    req_op = {OP_SUB, OP_NOP};
    rsp_ready = 2'b10;
    req_valid = 2'b10;
    #1;
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL sub_req_ready: got %b expected 10", req_ready); end
    cyc();
    req_valid = 2'b00;
    n_checks++; if (alu_op !== 8'h04 || alu_a !== 32'd3 || alu_b !== 32'd5) begin n_fail++; $display("FAIL sub_issue: got op %h a %h b %h expected 04/3/5", alu_op, alu_a, alu_b); end
    cyc();
    n_checks++; if (rsp_valid !== 2'b10) begin n_fail++; $display("FAIL sub_rsp_valid: got %b expected 10", rsp_valid); end
    n_checks++; if (rsp_data !== 32'hFFFFFFFE || rsp_flags !== 6'b011101) begin n_fail++; $display("FAIL sub_rsp: got %h/%b expected fffffffe/011101", rsp_data, rsp_flags); end
    cyc();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sub_done: busy got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    req_a = {32'd2, 32'd1};
    req_b = {32'd2, 32'd1};
    req_op = {OP_ADD, OP_ADD};
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL b2b_first_grant: got %b expected 01", req_ready); end
    cyc();
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL b2b_no_grant_issue: got %b expected 00", req_ready); end
    cyc();
    n_checks++; if (rsp_valid !== 2'b01 || rsp_data !== 32'd2) begin n_fail++; $display("FAIL b2b_rsp0: got %b/%h expected 01/00000002", rsp_valid, rsp_data); end
    cyc();
    n_checks++; if (busy !== 1'b0 || req_ready !== 2'b10) begin n_fail++; $display("FAIL b2b_second_grant: got busy %b ready %b expected 0/10", busy, req_ready); end
    cyc(); cyc();
    n_checks++; if (rsp_valid !== 2'b10 || rsp_data !== 32'd4) begin n_fail++; $display("FAIL b2b_rsp1: got %b/%h expected 10/00000004", rsp_valid, rsp_data); end
    cyc();
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL b2b_third_grant: got %b expected 01", req_ready); end
    req_valid = 2'b00;
    cyc();
  endtask

  task automatic test_unsupported();
    req_a = {32'd0, 32'h1234};
    req_b = {32'd0, 32'h0001};
    req_op = {OP_NOP, 8'h02};
    rsp_ready = 2'b01;
    req_valid = 2'b01;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL unsup_req_ready: got %b expected 01", req_ready); end
    cyc();
    req_valid = 2'b00;
    n_checks++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b1) begin n_fail++; $display("FAIL unsup_rsp: got valid %b err %b expected 01/1", rsp_valid, rsp_err); end
    n_checks++; if (rsp_data !== 32'd0 || rsp_flags !== 6'd0) begin n_fail++; $display("FAIL unsup_data: got %h/%b expected 0/0", rsp_data, rsp_flags); end
    n_checks++; if (alu_op !== 8'h00) begin n_fail++; $display("FAIL unsup_alu_op: got %h expected 00", alu_op); end
    cyc();
    n_checks++; if (busy !== 1'b0 || alu_op !== 8'h00) begin n_fail++; $display("FAIL unsup_done: got busy %b op %h expected 0/00", busy, alu_op); end
  endtask

  task automatic test_backpressure();
    req_a = {32'h000000F0, 32'd5};
    req_b = {32'h000000FF, 32'd7};
    req_op = {OP_XOR, OP_ADD};
    rsp_ready = 2'b00;
    req_valid = 2'b01;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL bp_req_ready: got %b expected 01", req_ready); end
    cyc();
    req_valid = 2'b10;
    rsp_ready = 2'b10;
    cyc();
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (rsp_valid !== 2'b01 || rsp_data !== 32'd12 || rsp_flags !== 6'd0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL bp_hold[%0d]: got %b/%h/%b/%b expected 01/0000000c/000000/0", i, rsp_valid, rsp_data, rsp_flags, rsp_err); end
      n_checks++; if (req_ready !== 2'b00 || busy !== 1'b1) begin n_fail++; $display("FAIL bp_stall[%0d]: got ready %b busy %b expected 00/1", i, req_ready, busy); end
      cyc();
    end
    rsp_ready = 2'b01;
    cyc();
    #1;
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 2'b00 || req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_release: got busy %b valid %b ready %b expected 0/00/10", busy, rsp_valid, req_ready); end
    rsp_ready = 2'b10;
    cyc();
    req_valid = 2'b00;
    n_checks++; if (alu_op !== 8'h07 || alu_a !== 32'hF0) begin n_fail++; $display("FAIL bp_issue1: got op %h a %h expected 07/000000f0", alu_op, alu_a); end
    cyc();
    n_checks++; if (rsp_valid !== 2'b10 || rsp_data !== 32'h0000000F || rsp_flags !== 6'd0) begin n_fail++; $display("FAIL bp_rsp1: got %b/%h/%b expected 10/0000000f/000000", rsp_valid, rsp_data, rsp_flags); end
    cyc();
  endtask

  task automatic test_reset_mid();
    req_a = {32'd0, 32'd9};
    req_b = {32'd0, 32'd1};
    req_op = {OP_NOP, OP_ADD};
    rsp_ready = 2'b01;
    req_valid = 2'b01;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rmid_req_ready: got %b expected 01", req_ready); end
    cyc();
    n_checks++; if (busy !== 1'b1 || alu_op !== 8'h03) begin n_fail++; $display("FAIL rmid_issue: got busy %b op %h expected 1/03", busy, alu_op); end
    rst = 1'b1;
    req_valid = 2'b00;
    #1;
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rmid_ready_in_rst: got %b expected 00", req_ready); end
    cyc();
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 2'b00 || alu_op !== 8'h00) begin n_fail++; $display("FAIL rmid_state: got busy %b valid %b op %h expected 0/00/00", busy, rsp_valid, alu_op); end
    n_checks++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || rsp_data !== 32'd0 || rsp_flags !== 6'd0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL rmid_regs: got a %h b %h d %h f %b e %b expected all 0", alu_a, alu_b, rsp_data, rsp_flags, rsp_err); end
    rst = 1'b0;
    cyc();
    n_checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_dropped: got valid %b busy %b expected 00/0", rsp_valid, busy); end
    req_valid = 2'b11;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rmid_ptr_reset: got %b expected 01", req_ready); end
    req_valid = 2'b00;
    cyc();
  endtask

  initial begin
    test_reset();
    test_add_req0();
    test_sub_req1();
    test_back_to_back();
    test_unsupported();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
